// File: rtl/accel_pkg.sv
// Shared packet and loader-state definitions for the accelerator stream loader,
// the core and the assembler-side packet packer.
package accel_pkg;

    typedef enum logic [1:0] {
        PKT_INSTR = 2'b00,
        PKT_DATA  = 2'b01,
        PKT_START = 2'b10,
        PKT_RSVD  = 2'b11
    } pkt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD_INSTR,
        ST_LOAD_DATA,
        ST_START
    } loader_state_e;

    // Header layout: packet type in the top HDR_TYPE_W bits, word count in the rest.
    localparam int HDR_TYPE_W = 2;

endpackage

// File: rtl/accel_loader.sv
// Stream-to-memory loader: decodes packet headers from a valid/ready word stream,
// writes instruction/data memories through registered write ports, and pulses start.
module accel_loader
    import accel_pkg::*;
#(
    parameter int WORD_W      = 16,
    parameter int NUM_SIZE    = 16,
    parameter int INSTR_WIDTH = 16,
    parameter int BUFFER_LEN  = 32,
    parameter int INSTR_DEPTH = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WORD_W-1:0]              in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           acc_busy,
    input  logic                           err_clr,
    output logic                           instr_we,
    output logic [$clog2(INSTR_DEPTH)-1:0] instr_addr,
    output logic [INSTR_WIDTH-1:0]         instr_wdata,
    output logic                           mem_we,
    output logic [$clog2(BUFFER_LEN)-1:0]  mem_addr,
    output logic [NUM_SIZE-1:0]            mem_wdata,
    output logic                           start,
    output logic                           busy,
    output logic                           err
);

    localparam int CNT_W = WORD_W - HDR_TYPE_W;
    localparam int IAW   = $clog2(INSTR_DEPTH);
    localparam int DAW   = $clog2(BUFFER_LEN);

    loader_state_e    state;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] remaining;
    pkt_type_e        hdr_type;
    logic [CNT_W-1:0] hdr_count;
    logic             xfer;
    logic             fits;
    logic             err_set;

    // Operands are two's complement; dropping high bits keeps the sign as long
    // as the host packed them at NUM_SIZE width.
    function automatic logic signed [NUM_SIZE-1:0] to_num(input logic [WORD_W-1:0] w);
        return w[NUM_SIZE-1:0];
    endfunction

    assign hdr_type  = pkt_type_e'(in_data[WORD_W-1 -: HDR_TYPE_W]);
    assign hdr_count = in_data[CNT_W-1:0];
    assign xfer      = in_valid & in_ready;
    assign busy      = (state != ST_IDLE);

    // Ready is forced low while reset is held so no word can slip in during reset.
    always_comb begin
        in_ready = 1'b0;
        if (rst) begin
            case (state)
                ST_IDLE:                     in_ready = ~acc_busy;
                ST_LOAD_INSTR, ST_LOAD_DATA: in_ready = 1'b1;
                default:                     in_ready = 1'b0;
            endcase
        end
    end

    always_comb begin
        fits = (state == ST_LOAD_INSTR) ? (int'(idx) < INSTR_DEPTH) : (int'(idx) < BUFFER_LEN);
        err_set = 1'b0;
        if (xfer) begin
            if (state == ST_IDLE && hdr_type == PKT_RSVD)
                err_set = 1'b1;
            else if ((state == ST_LOAD_INSTR || state == ST_LOAD_DATA) && !fits)
                err_set = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            idx         <= '0;
            remaining   <= '0;
            instr_we    <= 1'b0;
            instr_addr  <= '0;
            instr_wdata <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            start       <= 1'b0;
            err         <= 1'b0;
        end else begin
            instr_we <= 1'b0;
            mem_we   <= 1'b0;
            start    <= 1'b0;
            err      <= err_set | (err & ~err_clr);
            case (state)
                ST_IDLE: begin
                    if (xfer) begin
                        case (hdr_type)
                            PKT_INSTR, PKT_DATA: begin
                                if (hdr_count != '0) begin
                                    state     <= (hdr_type == PKT_INSTR) ? ST_LOAD_INSTR : ST_LOAD_DATA;
                                    idx       <= '0;
                                    remaining <= hdr_count;
                                end
                            end
                            PKT_START: begin
                                state <= ST_START;
                                start <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                // Words beyond the memory depth are drained without a write.
                ST_LOAD_INSTR, ST_LOAD_DATA: begin
                    if (xfer) begin
                        if (fits) begin
                            if (state == ST_LOAD_INSTR) begin
                                instr_we    <= 1'b1;
                                instr_addr  <= idx[IAW-1:0];
                                instr_wdata <= in_data[INSTR_WIDTH-1:0];
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= idx[DAW-1:0];
                                mem_wdata <= to_num(in_data);
                            end
                        end
                        idx       <= idx + 1'b1;
                        remaining <= remaining - 1'b1;
                        if (remaining == 1) state <= ST_IDLE;
                    end
                end
                ST_START: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_accel_loader.sv
// Scoreboard bench for accel_loader: packets are expanded into expected memory
// writes and start pulses by a packet-level model; a monitor checks every DUT event.
module tb_accel_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        acc_busy = 1'b0;
    logic        err_clr = 1'b0;
    logic        instr_we;
    logic [5:0]  instr_addr;
    logic [15:0] instr_wdata;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        start;
    logic        busy;
    logic        err;

    accel_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .acc_busy(acc_busy), .err_clr(err_clr), .instr_we(instr_we), .instr_addr(instr_addr),
        .instr_wdata(instr_wdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .start(start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 instruction write, 1 data write, 2 start pulse
        int          addr;
        logic [15:0] data;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] pw[$];
    int          data_wr_cyc[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    logic        model_err = 1'b0;
    logic        gaps_en = 1'b0;
    logic        busy_mid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: every write or start the DUT presents must match the next expected event.
    always @(negedge clk) begin
        if (rst && (instr_we || mem_we || start)) begin
            if (mem_we) data_wr_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {29'd0, instr_we, mem_we, start}, 32'd0);
            end else begin
                ev_t e;
                int  kind_act;
                e = exp_q.pop_front();
                kind_act = instr_we ? 0 : (mem_we ? 1 : 2);
                check("event_kind", kind_act, e.kind);
                if (e.kind == 0) begin
                    check("instr_addr", instr_addr, e.addr);
                    check("instr_wdata", instr_wdata, e.data);
                end else if (e.kind == 1) begin
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_wdata", mem_wdata, e.data);
                end else begin
                    check("start_ready_low", in_ready, 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic send(input logic [15:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) check("send_timeout", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_packet(input logic [1:0] t, input int cnt);
        logic [13:0] c;
        int          depth;
        c = cnt[13:0];
        if (t == 2'b11) model_err = 1'b1;
        if (t == 2'b10) exp_q.push_back('{kind: 2, addr: 0, data: 16'h0});
        send({t, c});
        if (t < 2'd2 && cnt > 0) begin
            depth = (t == 2'b00) ? 64 : 32;
            if (busy_mid) acc_busy = 1'($urandom_range(0, 1));
            for (int i = 0; i < cnt; i++) begin
                if (i < depth) exp_q.push_back('{kind: (t == 2'b00) ? 0 : 1, addr: i, data: pw[i]});
                else model_err = 1'b1;
                if (gaps_en) repeat ($urandom_range(0, 2)) @(negedge clk);
                send(pw[i]);
            end
            acc_busy = 1'b0;
        end
    endtask

    task automatic settle_and_check();
        repeat (3) @(negedge clk);
        check("err_flag", err, model_err);
        check("busy_idle", busy, 0);
        check("queue_drained", exp_q.size(), 0);
        if (model_err) begin
            err_clr = 1'b1;
            @(negedge clk);
            err_clr  = 1'b0;
            model_err = 1'b0;
            #1 check("err_cleared", err, 0);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [1:0] t;
        int         cnt;
        int         r;

        // Power-on reset
        #12;
        check("por_ctrl", {in_ready, instr_we, mem_we, start, busy, err}, 0);
        check("por_addr", {instr_addr, mem_addr}, 0);
        check("por_wdata", {instr_wdata, mem_wdata}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 check("idle_ready", in_ready, 1);
        @(negedge clk);

        // Signed data packet: 5, -2, 7 on consecutive cycles
        pw = '{16'h0005, 16'hFFFE, 16'h0007};
        data_wr_cyc.delete();
        send_packet(2'b01, 3);
        #1 check("last_write_visible", mem_we, 1);
        check("busy_after_last", busy, 0);
        @(negedge clk);
        check("data_writes_consecutive", data_wr_cyc.size() == 3 ? data_wr_cyc[2] - data_wr_cyc[0] : -1, 2);
        settle_and_check();

        // Instruction packet with a 3-cycle valid gap
        exp_q.push_back('{kind: 0, addr: 0, data: 16'h1234});
        send(16'h0002);
        send(16'h1234);
        repeat (3) @(negedge clk);
        check("busy_in_gap", busy, 1);
        exp_q.push_back('{kind: 0, addr: 1, data: 16'hABCD});
        send(16'hABCD);
        settle_and_check();

        // Data overflow: 34 words into a 32-deep memory
        pw.delete();
        for (int i = 0; i < 34; i++) pw.push_back(16'($urandom));
        send_packet(2'b01, 34);
        repeat (3) @(negedge clk);
        check("overflow_err", err, 1);
        settle_and_check();

        // Start gated by acc_busy
        acc_busy = 1'b1;
        in_data  = 16'h8000;
        in_valid = 1'b1;
        repeat (4) @(negedge clk);
        #1 check("gated_ready", in_ready, 0);
        exp_q.push_back('{kind: 2, addr: 0, data: 16'h0});
        acc_busy = 1'b0;
        #1 check("ungated_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        settle_and_check();

        // Reserved header, then clear colliding with a new error
        send_packet(2'b11, 0);
        #1 check("rsvd_err", err, 1);
        settle_and_check();
        err_clr = 1'b1;
        send_packet(2'b11, 0);
        err_clr = 1'b0;
        #1 check("set_beats_clear", err, 1);
        settle_and_check();

        // Randomized packets
        gaps_en  = 1'b1;
        busy_mid = 1'b1;
        for (int p = 0; p < 30; p++) begin
            r = $urandom_range(0, 9);
            t = (r < 4) ? 2'd0 : (r < 8) ? 2'd1 : (r == 8) ? 2'd2 : 2'd3;
            if (t < 2'd2) cnt = ($urandom_range(0, 6) == 0) ? ((t == 2'd0) ? 66 : 34) : $urandom_range(0, 6);
            else cnt = $urandom_range(0, 16383);
            pw.delete();
            if (t < 2'd2) for (int i = 0; i < cnt; i++) pw.push_back(16'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                acc_busy = 1'b1;
                fork
                    begin
                        repeat ($urandom_range(1, 5)) @(negedge clk);
                        acc_busy = 1'b0;
                    end
                join_none
            end
            send_packet(t, cnt);
            settle_and_check();
        end
        gaps_en  = 1'b0;
        busy_mid = 1'b0;

        // Asynchronous reset in the middle of a data packet
        exp_q.push_back('{kind: 1, addr: 0, data: 16'h1111});
        exp_q.push_back('{kind: 1, addr: 1, data: 16'h2222});
        send(16'h4005);
        send(16'h1111);
        send(16'h2222);
        repeat (2) @(negedge clk);
        check("mid_packet_busy", busy, 1);
        #2 rst = 1'b0;
        model_err = 1'b0;
        #1;
        check("async_rst_ctrl", {in_ready, instr_we, mem_we, start, busy, err}, 0);
        check("async_rst_addr", {instr_addr, mem_addr}, 0);
        check("async_rst_wdata", {instr_wdata, mem_wdata}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1 check("post_rst_idle", busy, 0);
        check("post_rst_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        check("final_drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
